// File: rtl/regfile_wr_arbiter.sv
// Two-requester register-file write arbiter.
// Requester 0 is the ALU writeback path and requester 1 is the load/multicycle
// unit. Ties are broken round-robin through a one-bit last_grant flag. The
// winning write is registered onto the register-file port one cycle later.
// Writes to register 0 are accepted but suppressed, and a saturating counter
// tracks how many were dropped.
module regfile_wr_arbiter #(
    parameter int n = 32,
    parameter int a = 5
) (
    input  logic         clk_port,
    input  logic         rst_port,

    input  logic         req0_valid_port,
    input  logic [a-1:0] req0_addr_port,
    input  logic [n-1:0] req0_data_port,
    output logic         req0_ready_port,

    input  logic         req1_valid_port,
    input  logic [a-1:0] req1_addr_port,
    input  logic [n-1:0] req1_data_port,
    output logic         req1_ready_port,

    output logic         wr_en_port,
    output logic [a-1:0] wr_addr_port,
    output logic [n-1:0] wr_data_port,
    output logic [7:0]   zero_drop_cnt_port
);

    // Index of the requester granted most recently. It resets to 1 so that
    // requester 0 wins the first tie.
    logic         r_last_grant;

    logic         r_wr_en;
    logic [a-1:0] r_wr_addr;
    logic [n-1:0] r_wr_data;
    logic [7:0]   r_zero_drop_cnt;

    logic [1:0]   w_grant;
    logic         w_xfer;
    logic         w_sel;
    logic [a-1:0] w_sel_addr;
    logic [n-1:0] w_sel_data;
    logic         w_sel_addr_zero;
    logic         w_cnt_sat;

    // Grant decision. It is purely combinational from the valids and
    // last_grant, and it is gated by reset so that no ready is raised while
    // reset is held. Only one grant bit can be set, so the two readies are
    // mutually exclusive.
    always_comb begin
        w_grant = 2'b00;
        if (rst_port) begin
            if (req0_valid_port && req1_valid_port) begin
                if (r_last_grant) begin
                    w_grant = 2'b01;
                end else begin
                    w_grant = 2'b10;
                end
            end else if (req0_valid_port) begin
                w_grant = 2'b01;
            end else if (req1_valid_port) begin
                w_grant = 2'b10;
            end
        end
    end

    assign req0_ready_port = w_grant[0];
    assign req1_ready_port = w_grant[1];

    assign w_xfer          = |w_grant;
    assign w_sel           = w_grant[1];
    assign w_sel_addr      = w_sel ? req1_addr_port : req0_addr_port;
    assign w_sel_data      = w_sel ? req1_data_port : req0_data_port;
    assign w_sel_addr_zero = (w_sel_addr == '0);
    assign w_cnt_sat       = (r_zero_drop_cnt == 8'hFF);

    // Round-robin state. It moves only when a transfer happens.
    always_ff @(posedge clk_port or negedge rst_port) begin
        if (!rst_port) begin
            r_last_grant <= 1'b1;
        end else if (w_xfer) begin
            r_last_grant <= w_sel;
        end
    end

    // Registered write port. Address and data follow every accepted transfer,
    // including writes to register 0, and otherwise hold their values. The
    // enable is a one-cycle pulse and is suppressed for register 0.
    always_ff @(posedge clk_port or negedge rst_port) begin
        if (!rst_port) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= w_xfer && !w_sel_addr_zero;
            if (w_xfer) begin
                r_wr_addr <= w_sel_addr;
                r_wr_data <= w_sel_data;
            end
        end
    end

    // Count of dropped register-0 writes. It saturates at 255 rather than
    // wrapping around.
    always_ff @(posedge clk_port or negedge rst_port) begin
        if (!rst_port) begin
            r_zero_drop_cnt <= 8'd0;
        end else if (w_xfer && w_sel_addr_zero && !w_cnt_sat) begin
            r_zero_drop_cnt <= r_zero_drop_cnt + 8'd1;
        end
    end

    assign wr_en_port         = r_wr_en;
    assign wr_addr_port       = r_wr_addr;
    assign wr_data_port       = r_wr_data;
    assign zero_drop_cnt_port = r_zero_drop_cnt;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Scoreboard bench for regfile_wr_arbiter. Each cycle the bench drives the
// requests, checks the combinational readies against a reference model, and
// pushes the expected registered write onto a queue. After the next rising
// edge it pops that entry and compares it with the write port.
module tb_regfile_wr_arbiter;

    localparam int N = 32;
    localparam int A = 5;

    logic         clk_port;
    logic         rst_port;
    logic         req0_valid_port;
    logic [A-1:0] req0_addr_port;
    logic [N-1:0] req0_data_port;
    logic         req0_ready_port;
    logic         req1_valid_port;
    logic [A-1:0] req1_addr_port;
    logic [N-1:0] req1_data_port;
    logic         req1_ready_port;
    logic         wr_en_port;
    logic [A-1:0] wr_addr_port;
    logic [N-1:0] wr_data_port;
    logic [7:0]   zero_drop_cnt_port;

    regfile_wr_arbiter #(.n(N), .a(A)) dut (
        .clk_port           (clk_port),
        .rst_port           (rst_port),
        .req0_valid_port    (req0_valid_port),
        .req0_addr_port     (req0_addr_port),
        .req0_data_port     (req0_data_port),
        .req0_ready_port    (req0_ready_port),
        .req1_valid_port    (req1_valid_port),
        .req1_addr_port     (req1_addr_port),
        .req1_data_port     (req1_data_port),
        .req1_ready_port    (req1_ready_port),
        .wr_en_port         (wr_en_port),
        .wr_addr_port       (wr_addr_port),
        .wr_data_port       (wr_data_port),
        .zero_drop_cnt_port (zero_drop_cnt_port)
    );

    initial clk_port = 1'b0;
    always #5 clk_port = ~clk_port;

    typedef struct {
        logic         en;
        logic [A-1:0] addr;
        logic [N-1:0] data;
        logic [7:0]   cnt;
    } exp_t;

    exp_t sb_q[$];

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic         m_last;
    logic [A-1:0] m_addr;
    logic [N-1:0] m_data;
    logic [7:0]   m_cnt;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_last = 1'b1;
        m_addr = '0;
        m_data = '0;
        m_cnt  = 8'd0;
    endtask

    // Called at posedge+1. It drives one cycle of requests, checks the
    // readies, predicts the write, waits one edge and then scores the result.
    task automatic drive_cycle(input logic v0, input logic [A-1:0] a0, input logic [N-1:0] d0,
                               input logic v1, input logic [A-1:0] a1, input logic [N-1:0] d1,
                               input string tag, input bit verbose);
        logic g0, g1;
        exp_t e, o;
        req0_valid_port = v0; req0_addr_port = a0; req0_data_port = d0;
        req1_valid_port = v1; req1_addr_port = a1; req1_data_port = d1;
        #1;
        g0 = v0 && (!v1 || m_last);
        g1 = v1 && (!v0 || !m_last);
        check_val({tag, ".ready0"}, 64'(req0_ready_port), 64'(g0));
        check_val({tag, ".ready1"}, 64'(req1_ready_port), 64'(g1));
        e.en = 1'b0;
        if (g0 || g1) begin
            m_last = g1;
            m_addr = g1 ? a1 : a0;
            m_data = g1 ? d1 : d0;
            e.en   = (m_addr != '0);
            if (m_addr == '0 && m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
        end
        e.addr = m_addr;
        e.data = m_data;
        e.cnt  = m_cnt;
        sb_q.push_back(e);
        @(posedge clk_port);
        #1;
        o = sb_q.pop_front();
        check_val({tag, ".wr_en"},   64'(wr_en_port),         64'(o.en));
        check_val({tag, ".wr_addr"}, 64'(wr_addr_port),       64'(o.addr));
        check_val({tag, ".wr_data"}, 64'(wr_data_port),       64'(o.data));
        check_val({tag, ".zcnt"},    64'(zero_drop_cnt_port), 64'(o.cnt));
        if (verbose)
            $display("xfer %s: g0=%0b g1=%0b wr_en=%0b addr=%0d data=0x%08h cnt=%0d",
                     tag, g0, g1, wr_en_port, wr_addr_port, wr_data_port, zero_drop_cnt_port);
    endtask

    // Called at posedge+1. It holds reset across one edge and releases it
    // one time unit after that edge.
    task automatic apply_reset();
        rst_port = 1'b0;
        @(posedge clk_port);
        #1;
        rst_port = 1'b1;
        model_reset();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_port        = 1'b0;
        req0_valid_port = 1'b1; req0_addr_port = 5'd7; req0_data_port = 32'h1111_1111;
        req1_valid_port = 1'b1; req1_addr_port = 5'd8; req1_data_port = 32'h2222_2222;
        model_reset();
        #2;
        // During reset the outputs are zero and no ready is raised.
        check_val("rst.wr_en",   64'(wr_en_port), 64'd0);
        check_val("rst.wr_addr", 64'(wr_addr_port), 64'd0);
        check_val("rst.wr_data", 64'(wr_data_port), 64'd0);
        check_val("rst.zcnt",    64'(zero_drop_cnt_port), 64'd0);
        check_val("rst.ready0",  64'(req0_ready_port), 64'd0);
        check_val("rst.ready1",  64'(req1_ready_port), 64'd0);
        @(posedge clk_port);
        #1;
        check_val("rst_edge.wr_en", 64'(wr_en_port), 64'd0);
        rst_port = 1'b1;
        model_reset();

        // Single requester 0 write, followed by an idle cycle.
        drive_cycle(1, 5'd3, 32'hDEADBEEF, 0, 5'd0, 32'h0, "single0", 1);
        drive_cycle(0, 5'd0, 32'h0,        0, 5'd0, 32'h0, "idle",    1);

        // Both requesters valid straight after reset give grants 0,1,0,1.
        apply_reset();
        for (int i = 0; i < 4; i++)
            drive_cycle(1, 5'd1, 32'hA000_0000 + i, 1, 5'd2, 32'hB000_0000 + i, "tie_rr", 1);

        // A register-0 write from requester 1 is dropped and counted.
        drive_cycle(0, 5'd0, 32'h0, 1, 5'd0, 32'h5, "zero1", 1);

        // req0 alone, then req1 alone twice, then a tie that goes to req0.
        drive_cycle(1, 5'd9,  32'h0909_0909, 0, 5'd0,  32'h0,         "r36_0", 1);
        drive_cycle(0, 5'd0,  32'h0,         1, 5'd10, 32'h1010_1010, "r36_1", 1);
        drive_cycle(0, 5'd0,  32'h0,         1, 5'd11, 32'h1111_0000, "r36_2", 1);
        drive_cycle(1, 5'd12, 32'h1212_1212, 1, 5'd13, 32'h1313_1313, "r36_3", 1);

        // Dropping valid leaves the arbiter state untouched.
        drive_cycle(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, "idle2", 1);
        drive_cycle(1, 5'd14, 32'h1414_1414, 1, 5'd15, 32'h1515_1515, "tie_after_idle", 1);

        // 300 register-0 writes saturate the counter at 255.
        for (int i = 0; i < 300; i++)
            drive_cycle(i[0], 5'd0, 32'(i), !i[0], 5'd0, 32'(i + 1000), "zsat", 0);
        check_val("zsat.final", 64'(zero_drop_cnt_port), 64'd255);
        $display("xfer zsat: 300 addr=0 transfers, cnt=%0d", zero_drop_cnt_port);

        // Reset asserted between edges while a write is in flight.
        drive_cycle(1, 5'd17, 32'hCAFE_F00D, 0, 5'd0, 32'h0, "pre_async", 1);
        #2;
        rst_port = 1'b0;
        #1;
        check_val("async.wr_en",   64'(wr_en_port), 64'd0);
        check_val("async.wr_addr", 64'(wr_addr_port), 64'd0);
        check_val("async.wr_data", 64'(wr_data_port), 64'd0);
        check_val("async.zcnt",    64'(zero_drop_cnt_port), 64'd0);
        req0_valid_port = 1'b1; req1_valid_port = 1'b1;
        #1;
        check_val("async.ready0", 64'(req0_ready_port), 64'd0);
        check_val("async.ready1", 64'(req1_ready_port), 64'd0);
        @(posedge clk_port);
        #1;
        check_val("async_edge.wr_en", 64'(wr_en_port), 64'd0);
        rst_port = 1'b1;
        model_reset();

        // The first edge after reset release is a normal arbitration cycle.
        drive_cycle(1, 5'd20, 32'h2020_2020, 1, 5'd21, 32'h2121_2121, "post_rst", 1);
        drive_cycle(1, 5'd20, 32'h2020_2020, 1, 5'd21, 32'h2121_2121, "post_rst", 1);

        check_val("sb.empty", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
